mc_controller: RTL and testbench

- Multicycle main controller for the MIPS32 core.
- Sequences one shared ALU, the instruction/data memory port, the PC and the register file across FETCH/DECODE/EXECUTE/MEM/WB steps.
- Emits the 4-bit aluop consumed by the ALU decoder; the decoder resolves aluop 4'b1111 through funct.
- Stalls on a memory ready handshake and flags illegal opcodes.

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/aluopsel.sv | 28 ++
 rtl/mc_controller.sv | 146 ++++++++++++++
 tb/tb_mc_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS32 multicycle controller: opcodes, ALU operation
// classes and the controller state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_BLEZ = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_LUI  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_BGTZ = 4'b1000;

    localparam logic [3:0] RTYPE_ALUOP = 4'b1111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12
    } statetype_t;

endpackage

// File: rtl/aluopsel.sv
// Opcode to ALU operation class for immediate and branch instructions, plus
// zero-extension select for the logical immediates.
module aluopsel
    import mips_pkg::*;
(
    input  logic [5:0] op,
    output logic [3:0] aluop,
    output logic       immzext
);

    always_comb begin
        aluop   = ALU_ADD;
        immzext = 1'b0;
        case (op)
            OP_ADDI: aluop = ALU_ADD;
            OP_SLTI: aluop = ALU_SLT;
            OP_ANDI: begin aluop = ALU_AND; immzext = 1'b1; end
            OP_ORI:  begin aluop = ALU_OR;  immzext = 1'b1; end
            OP_XORI: begin aluop = ALU_XOR; immzext = 1'b1; end
            OP_LUI:  aluop = ALU_LUI;
            OP_BEQ:  aluop = ALU_SUB;
            OP_BLEZ: aluop = ALU_BLEZ;
            OP_BGTZ: aluop = ALU_BGTZ;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main controller: sequences ALU, memory port, PC and register file
// for one instruction at a time, stalling on mem_ready in the memory states.
//   state  | meaning
//   FETCH  | read instruction, PC+4          DECODE | read regs, branch target
//   MEMADR | compute load/store address      MEMRD  | data read, waits mem_ready
//   MEMWB  | load writeback                  MEMWR  | data write, waits mem_ready
//   RTEXEC | R-type ALU op                   RTWB   | R-type writeback to rd
//   BRANCH | compare, PC<-ALUOut if zero     IEXEC  | immediate ALU op
//   IWB    | immediate writeback to rt       JUMP   | PC<-jump target
//   JR     | PC<-rs
module mc_controller #(
    parameter logic [3:0] RTYPE_ALUOP = 4'b1111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       immzext,
    output logic [1:0] pcsrc,
    output logic [3:0] aluop,
    output logic       illegal
);
    import mips_pkg::*;

    statetype_t state, state_next;
    logic       pcwrite, branch, illegal_set;
    logic       irwrite_c, memwrite_c, regwrite_c;
    logic [3:0] sel_aluop;
    logic       sel_immzext;

    aluopsel u_aluopsel (
        .op      (op),
        .aluop   (sel_aluop),
        .immzext (sel_immzext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (illegal_set) illegal <= 1'b1;
        end
    end

    always_comb begin
        state_next  = S_FETCH;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        illegal_set = 1'b0;
        irwrite_c   = 1'b0;
        memwrite_c  = 1'b0;
        regwrite_c  = 1'b0;
        iord        = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        immzext     = 1'b0;
        pcsrc       = 2'b00;
        aluop       = ALU_ADD;
        case (state)
            S_FETCH: begin
                alusrcb    = 2'b01;
                irwrite_c  = mem_ready;
                pcwrite    = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:                   state_next = S_MEMADR;
                    OP_RTYPE:                       state_next = (funct == FUNCT_JR) ? S_JR : S_RTEXEC;
                    OP_BEQ, OP_BLEZ, OP_BGTZ:       state_next = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI:        state_next = S_IEXEC;
                    OP_J:                           state_next = S_JUMP;
                    default:                        illegal_set = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTEXEC: begin
                alusrca    = 1'b1;
                aluop      = RTYPE_ALUOP;
                state_next = S_RTWB;
            end
            S_RTWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                branch  = 1'b1;
                pcsrc   = 2'b01;
                aluop   = sel_aluop;
            end
            S_IEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                aluop      = sel_aluop;
                immzext    = sel_immzext;
                state_next = S_IWB;
            end
            S_IWB:  regwrite_c = 1'b1;
            S_JUMP: begin pcsrc = 2'b10; pcwrite = 1'b1; end
            S_JR:   begin pcsrc = 2'b11; pcwrite = 1'b1; end
            default: ;
        endcase
    end

    // Write enables are masked by reset so nothing commits while it is held low.
    assign pcen     = (pcwrite | (branch & zero)) & reset;
    assign irwrite  = irwrite_c & reset;
    assign memwrite = memwrite_c & reset;
    assign regwrite = regwrite_c & reset;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle
// and compares the full output vector against hand-derived values.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       immzext, illegal;
    logic [3:0] aluop;

    int checks   = 0;
    int failures = 0;

    mc_controller dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcen      (pcen),
        .irwrite   (irwrite),
        .memwrite  (memwrite),
        .iord      (iord),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .immzext   (immzext),
        .pcsrc     (pcsrc),
        .aluop     (aluop),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca,
                  alusrcb, immzext, pcsrc, aluop, illegal};

    function automatic logic [17:0] ov(
        input logic pe, input logic irw, input logic mw, input logic io,
        input logic rw, input logic rd, input logic m2r, input logic asa,
        input logic [1:0] asb, input logic iz, input logic [1:0] ps,
        input logic [3:0] ao, input logic ill);
        return {pe, irw, mw, io, rw, rd, m2r, asa, asb, iz, ps, ao, ill};
    endfunction

    task automatic chk(input string tag, input logic [17:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FETCH (mem_ready=1) then DECODE; leaves the controller in the execute state.
    task automatic fd(input string tag, input logic ill);
        #1;
        chk({tag, "_fetch"}, ov(1,1,0,0,0,0,0,0,2'b01,0,2'b00,4'b0000,ill));
        tick();
        chk({tag, "_decode"}, ov(0,0,0,0,0,0,0,0,2'b11,0,2'b00,4'b0000,ill));
        tick();
    endtask

    initial begin
        reset = 1'b0; op = 6'b000000; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        #1;
        chk("reset_hold", ov(0,0,0,0,0,0,0,0,2'b01,0,2'b00,4'b0000,0));
        tick(); tick();
        reset = 1'b1;

        // FETCH wait state
        mem_ready = 1'b0;
        #1;
        chk("fetch_wait", ov(0,0,0,0,0,0,0,0,2'b01,0,2'b00,4'b0000,0));
        tick();

        // lw, no wait states: 5 cycles
        mem_ready = 1'b1; op = 6'b100011;
        fd("lw", 1'b0);
        chk("lw_memadr", ov(0,0,0,0,0,0,0,1,2'b10,0,2'b00,4'b0000,0));
        tick();
        chk("lw_memrd", ov(0,0,0,1,0,0,0,0,2'b00,0,2'b00,4'b0000,0));
        tick();
        chk("lw_memwb", ov(0,0,0,0,1,0,1,0,2'b00,0,2'b00,4'b0000,0));
        tick();

        // sw with three wait cycles in MEMWR
        op = 6'b101011;
        fd("sw", 1'b0);
        chk("sw_memadr", ov(0,0,0,0,0,0,0,1,2'b10,0,2'b00,4'b0000,0));
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sw_memwr_wait", ov(0,0,1,1,0,0,0,0,2'b00,0,2'b00,4'b0000,0));
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_memwr_done", ov(0,0,1,1,0,0,0,0,2'b00,0,2'b00,4'b0000,0));
        tick();
        chk("sw_back_fetch", ov(1,1,0,0,0,0,0,0,2'b01,0,2'b00,4'b0000,0));

        // beq taken / not taken, bgtz
        op = 6'b000100; zero = 1'b1;
        fd("beq_t", 1'b0);
        chk("beq_taken", ov(1,0,0,0,0,0,0,1,2'b00,0,2'b01,4'b0001,0));
        tick();
        zero = 1'b0;
        fd("beq_nt", 1'b0);
        chk("beq_not_taken", ov(0,0,0,0,0,0,0,1,2'b00,0,2'b01,4'b0001,0));
        tick();
        op = 6'b000111;
        fd("bgtz", 1'b0);
        chk("bgtz_branch", ov(0,0,0,0,0,0,0,1,2'b00,0,2'b01,4'b1000,0));
        tick();

        // ori
        op = 6'b001101;
        fd("ori", 1'b0);
        chk("ori_iexec", ov(0,0,0,0,0,0,0,1,2'b10,1,2'b00,4'b0011,0));
        tick();
        chk("ori_iwb", ov(0,0,0,0,1,0,0,0,2'b00,0,2'b00,4'b0000,0));
        tick();

        // R-type add
        op = 6'b000000; funct = 6'b100000;
        fd("radd", 1'b0);
        chk("radd_rtexec", ov(0,0,0,0,0,0,0,1,2'b00,0,2'b00,4'b1111,0));
        tick();
        chk("radd_rtwb", ov(0,0,0,0,1,1,0,0,2'b00,0,2'b00,4'b0000,0));
        tick();

        // jr: 3 cycles then back to FETCH
        funct = 6'b001000;
        fd("jr", 1'b0);
        chk("jr_exec", ov(1,0,0,0,0,0,0,0,2'b00,0,2'b11,4'b0000,0));
        tick();
        chk("jr_back_fetch", ov(1,1,0,0,0,0,0,0,2'b01,0,2'b00,4'b0000,0));

        // j
        op = 6'b000010;
        fd("j", 1'b0);
        chk("j_jump", ov(1,0,0,0,0,0,0,0,2'b00,0,2'b10,4'b0000,0));
        tick();

        // illegal opcode: flag appears after DECODE, back to FETCH
        op = 6'b111111;
        fd("ill", 1'b0);
        chk("ill_set_fetch", ov(1,1,0,0,0,0,0,0,2'b01,0,2'b00,4'b0000,1));

        // sw stalled in MEMWR, reset asserted mid-write
        op = 6'b101011;
        fd("sw2", 1'b1);
        chk("sw2_memadr", ov(0,0,0,0,0,0,0,1,2'b10,0,2'b00,4'b0000,1));
        tick();
        mem_ready = 1'b0;
        #1;
        chk("sw2_memwr", ov(0,0,1,1,0,0,0,0,2'b00,0,2'b00,4'b0000,1));
        reset = 1'b0;
        #1;
        chk("rst_mid_write", ov(0,0,0,0,0,0,0,0,2'b01,0,2'b00,4'b0000,0));
        mem_ready = 1'b1;
        #1;
        chk("rst_gate_ready", ov(0,0,0,0,0,0,0,0,2'b01,0,2'b00,4'b0000,0));
        tick();
        reset = 1'b1;
        #1;
        chk("post_reset_fetch", ov(1,1,0,0,0,0,0,0,2'b01,0,2'b00,4'b0000,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
